// File: rtl/riscv_vec_cmd_queue_pkg.sv
// Shared payload widths and queue depth for the vector command queue slice.
package riscv_vec_cmd_queue_pkg;

    localparam int CMD_W         = 20;
    localparam int IMM1_W        = 64;
    localparam int IMM2_W        = 32;
    localparam int DEPTH_DEFAULT = 8;

    typedef logic [CMD_W-1:0]  cmd_t;
    typedef logic [IMM1_W-1:0] imm1_t;
    typedef logic [IMM2_W-1:0] imm2_t;

endpackage

// File: rtl/riscv_vec_cmd_queue_if.sv
// Enqueue bundle from execute plus the three independent dequeue ports toward the vector unit.
interface riscv_vec_cmd_queue_if
    import riscv_vec_cmd_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
);

    logic enq_val;
    logic enq_cmd;
    logic enq_imm1;
    logic enq_imm2;
    cmd_t  enq_cmd_bits;
    imm1_t enq_imm1_bits;
    imm2_t enq_imm2_bits;
    logic enq_rdy;

    logic  cmdq_val;
    logic  cmdq_rdy;
    cmd_t  cmdq_bits;
    logic  ximm1q_val;
    logic  ximm1q_rdy;
    imm1_t ximm1q_bits;
    logic  ximm2q_val;
    logic  ximm2q_rdy;
    imm2_t ximm2q_bits;

    logic [$clog2(DEPTH):0] cmdq_count;

    modport slave (
        input  enq_val, enq_cmd, enq_imm1, enq_imm2,
        input  enq_cmd_bits, enq_imm1_bits, enq_imm2_bits,
        output enq_rdy,
        output cmdq_val, cmdq_bits, ximm1q_val, ximm1q_bits, ximm2q_val, ximm2q_bits,
        input  cmdq_rdy, ximm1q_rdy, ximm2q_rdy,
        output cmdq_count
    );

    modport master (
        output enq_val, enq_cmd, enq_imm1, enq_imm2,
        output enq_cmd_bits, enq_imm1_bits, enq_imm2_bits,
        input  enq_rdy,
        input  cmdq_val, cmdq_bits, ximm1q_val, ximm1q_bits, ximm2q_val, ximm2q_bits,
        output cmdq_rdy, ximm1q_rdy, ximm2q_rdy,
        input  cmdq_count
    );

endinterface

// File: rtl/riscv_queue.sv
// Generic single-clock FIFO; ready and valid come from the registered count only,
// and the head entry is read straight out of storage (no enq-to-deq bypass).
module riscv_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq_val_i,
    output logic                   enq_rdy_o,
    input  logic [WIDTH-1:0]       enq_bits_i,
    output logic                   deq_val_o,
    input  logic                   deq_rdy_i,
    output logic [WIDTH-1:0]       deq_bits_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             push, pop;

    assign enq_rdy_o  = (count_q != FULL);
    assign deq_val_o  = (count_q != '0);
    assign push       = enq_val_i & enq_rdy_o;
    assign pop        = deq_val_o & deq_rdy_i;
    assign deq_bits_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enq_bits_i;
        end
    end

endmodule

// File: rtl/riscv_vec_cmd_queue.sv
// Vector command/immediate queues: one instruction pushes all of its selected queues
// atomically, and each queue drains toward the vector unit on its own handshake.
module riscv_vec_cmd_queue
    import riscv_vec_cmd_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    riscv_vec_cmd_queue_if.slave q
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          cmd_rdy, imm1_rdy, imm2_rdy;
    logic          enq_rdy, fire;
    logic [CW-1:0] imm1_count, imm2_count;
    logic          unused_counts;

    // Readiness only looks at registered fullness, so a pop this cycle cannot unblock a push.
    assign enq_rdy   = (~q.enq_cmd  | cmd_rdy)
                     & (~q.enq_imm1 | imm1_rdy)
                     & (~q.enq_imm2 | imm2_rdy);
    assign fire      = q.enq_val & enq_rdy;
    assign q.enq_rdy = enq_rdy;

    assign unused_counts = ^{imm1_count, imm2_count};

    riscv_queue #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmdq (
        .clk        (clk),
        .reset      (reset),
        .enq_val_i  (fire & q.enq_cmd),
        .enq_rdy_o  (cmd_rdy),
        .enq_bits_i (q.enq_cmd_bits),
        .deq_val_o  (q.cmdq_val),
        .deq_rdy_i  (q.cmdq_rdy),
        .deq_bits_o (q.cmdq_bits),
        .count_o    (q.cmdq_count)
    );

    riscv_queue #(.WIDTH(IMM1_W), .DEPTH(DEPTH)) u_ximm1q (
        .clk        (clk),
        .reset      (reset),
        .enq_val_i  (fire & q.enq_imm1),
        .enq_rdy_o  (imm1_rdy),
        .enq_bits_i (q.enq_imm1_bits),
        .deq_val_o  (q.ximm1q_val),
        .deq_rdy_i  (q.ximm1q_rdy),
        .deq_bits_o (q.ximm1q_bits),
        .count_o    (imm1_count)
    );

    riscv_queue #(.WIDTH(IMM2_W), .DEPTH(DEPTH)) u_ximm2q (
        .clk        (clk),
        .reset      (reset),
        .enq_val_i  (fire & q.enq_imm2),
        .enq_rdy_o  (imm2_rdy),
        .enq_bits_i (q.enq_imm2_bits),
        .deq_val_o  (q.ximm2q_val),
        .deq_rdy_i  (q.ximm2q_rdy),
        .deq_bits_o (q.ximm2q_bits),
        .count_o    (imm2_count)
    );

endmodule

// File: tb/tb_riscv_vec_cmd_queue.sv
// Directed and randomized bench for riscv_vec_cmd_queue against a queue-based reference model.
module tb_riscv_vec_cmd_queue;
    import riscv_vec_cmd_queue_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    riscv_vec_cmd_queue_if #(.DEPTH(DEPTH)) bus ();
    riscv_vec_cmd_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .q(bus));

    int nchecks = 0;
    int nerr    = 0;

    cmd_t  m_cmd  [$];
    imm1_t m_imm1 [$];
    imm2_t m_imm2 [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_rdy();
        return (!bus.enq_cmd  || m_cmd.size()  < DEPTH) &&
               (!bus.enq_imm1 || m_imm1.size() < DEPTH) &&
               (!bus.enq_imm2 || m_imm2.size() < DEPTH);
    endfunction

    task automatic compare_all();
        check("enq_rdy", 64'(bus.enq_rdy), 64'(model_rdy()));
        check("cmdq_val", 64'(bus.cmdq_val), 64'(m_cmd.size() != 0));
        check("ximm1q_val", 64'(bus.ximm1q_val), 64'(m_imm1.size() != 0));
        check("ximm2q_val", 64'(bus.ximm2q_val), 64'(m_imm2.size() != 0));
        check("cmdq_count", 64'(bus.cmdq_count), 64'(m_cmd.size()));
        if (m_cmd.size()  != 0) check("cmdq_bits",   64'(bus.cmdq_bits),   64'(m_cmd[0]));
        if (m_imm1.size() != 0) check("ximm1q_bits", 64'(bus.ximm1q_bits), 64'(m_imm1[0]));
        if (m_imm2.size() != 0) check("ximm2q_bits", 64'(bus.ximm2q_bits), 64'(m_imm2[0]));
    endtask

    task automatic settle();
        @(negedge clk);
        compare_all();
    endtask

    // Advance one edge and apply the queue rules to the model; inputs move #1 later.
    task automatic clock();
        bit fire, pc, p1, p2;
        @(posedge clk);
        fire = bus.enq_val && model_rdy();
        pc = bus.cmdq_rdy   && m_cmd.size()  != 0;
        p1 = bus.ximm1q_rdy && m_imm1.size() != 0;
        p2 = bus.ximm2q_rdy && m_imm2.size() != 0;
        if (pc) void'(m_cmd.pop_front());
        if (p1) void'(m_imm1.pop_front());
        if (p2) void'(m_imm2.pop_front());
        if (fire && bus.enq_cmd)  m_cmd.push_back(bus.enq_cmd_bits);
        if (fire && bus.enq_imm1) m_imm1.push_back(bus.enq_imm1_bits);
        if (fire && bus.enq_imm2) m_imm2.push_back(bus.enq_imm2_bits);
        #1;
    endtask

    task automatic step();
        settle();
        clock();
    endtask

    task automatic set_enq(input bit v, input bit c, input bit i1, input bit i2);
        bus.enq_val       = v;
        bus.enq_cmd       = c;
        bus.enq_imm1      = i1;
        bus.enq_imm2      = i2;
        bus.enq_cmd_bits  = cmd_t'($urandom);
        bus.enq_imm1_bits = {$urandom, $urandom};
        bus.enq_imm2_bits = $urandom;
    endtask

    task automatic set_rdy(input bit c, input bit i1, input bit i2);
        bus.cmdq_rdy   = c;
        bus.ximm1q_rdy = i1;
        bus.ximm2q_rdy = i2;
    endtask

    initial begin
        reset = 1'b1;
        set_enq(0, 0, 0, 0);
        set_rdy(0, 0, 0);
        #2;
        check("reset_count", 64'(bus.cmdq_count), 64'd0);
        check("reset_enq_rdy", 64'(bus.enq_rdy), 64'd1);
        compare_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single instruction writing all three queues, then drained.
        set_enq(1, 1, 1, 1);
        bus.enq_cmd_bits  = 20'h4_0001;
        bus.enq_imm1_bits = 64'hDEAD;
        bus.enq_imm2_bits = 32'hBEEF;
        set_rdy(1, 1, 1);
        step();
        set_enq(0, 0, 0, 0);
        settle();
        check("push_cmd_bits", 64'(bus.cmdq_bits), 64'h4_0001);
        check("push_imm1_bits", 64'(bus.ximm1q_bits), 64'hDEAD);
        check("push_imm2_bits", 64'(bus.ximm2q_bits), 64'hBEEF);
        check("push_all_val", 64'({bus.cmdq_val, bus.ximm1q_val, bus.ximm2q_val}), 64'b111);
        clock();
        settle();
        check("drained_count", 64'(bus.cmdq_count), 64'd0);
        clock();

        // Fill the command queue.
        set_rdy(0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            set_enq(1, 1, 0, 0);
            step();
        end
        set_enq(1, 1, 0, 0);
        settle();
        check("full_count", 64'(bus.cmdq_count), 64'd8);
        check("full_enq_rdy_cmd", 64'(bus.enq_rdy), 64'd0);
        set_enq(1, 0, 1, 0);
        #1;
        check("full_enq_rdy_imm1", 64'(bus.enq_rdy), 64'd1);
        clock();

        // Full queue popping in the same cycle still refuses the push.
        set_enq(1, 1, 0, 0);
        set_rdy(1, 0, 0);
        settle();
        check("full_pop_enq_rdy", 64'(bus.enq_rdy), 64'd0);
        clock();
        set_rdy(0, 0, 0);
        settle();
        check("after_pop_count", 64'(bus.cmdq_count), 64'd7);
        check("after_pop_enq_rdy", 64'(bus.enq_rdy), 64'd1);
        clock();
        settle();
        check("refill_count", 64'(bus.cmdq_count), 64'd8);
        clock();

        // Bring cmdq to 5, fill ximm1q, then ask for cmd+imm1.
        set_enq(0, 0, 0, 0);
        set_rdy(1, 0, 0);
        for (int i = 0; i < 3; i++) step();
        set_rdy(0, 0, 0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            set_enq(1, 0, 1, 0);
            step();
        end
        set_enq(1, 1, 1, 0);
        settle();
        check("atomic_enq_rdy", 64'(bus.enq_rdy), 64'd0);
        clock();
        settle();
        check("atomic_no_partial", 64'(bus.cmdq_count), 64'd5);
        clock();
        set_rdy(0, 1, 0);
        settle();
        check("atomic_pop_enq_rdy", 64'(bus.enq_rdy), 64'd0);
        clock();
        set_rdy(0, 0, 0);
        settle();
        check("atomic_freed_rdy", 64'(bus.enq_rdy), 64'd1);
        clock();
        settle();
        check("atomic_pushed", 64'(bus.cmdq_count), 64'd6);
        clock();

        // Drain everything, then stream through ximm2q across several pointer wraps.
        set_enq(0, 0, 0, 0);
        set_rdy(1, 1, 1);
        for (int i = 0; i < DEPTH + 2; i++) step();
        for (int i = 0; i < 20; i++) begin
            set_enq(1, 0, 0, 1);
            step();
        end
        set_enq(0, 0, 0, 0);
        step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            set_enq($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1));
            set_rdy($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1));
            step();
        end

        // Build count 5, then assert reset between clock edges.
        set_enq(0, 0, 0, 0);
        set_rdy(1, 1, 1);
        for (int i = 0; i < DEPTH + 2; i++) step();
        set_rdy(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            set_enq(1, 1, 1, 0);
            step();
        end
        set_enq(0, 0, 0, 0);
        settle();
        check("pre_reset_count", 64'(bus.cmdq_count), 64'd5);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_count", 64'(bus.cmdq_count), 64'd0);
        check("async_reset_val", 64'({bus.cmdq_val, bus.ximm1q_val, bus.ximm2q_val}), 64'd0);
        check("async_reset_enq_rdy", 64'(bus.enq_rdy), 64'd1);
        m_cmd.delete();
        m_imm1.delete();
        m_imm2.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_rdy(1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            set_enq(1, 1, 1, 1);
            step();
        end
        set_enq(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/riscv_vec_cmd_queue.md
RISCV_VEC_CMD_QUEUE -- requirements
Module: riscv_vec_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entries per queue; power of two, at least 2.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port enq_val, input, 1, execute stage presents a vector instruction.
REQ-005 SHALL have port enq_cmd / enq_imm1 / enq_imm2, input, 1 each, selects which queues this instruction writes.
REQ-006 SHALL have port enq_cmd_bits / enq_imm1_bits / enq_imm2_bits, input, 20 / 64 / 32, payloads taken from the datapath's vec_cmdq_bits / vec_ximm1q_bits / vec_ximm2q_bits.
REQ-007 SHALL have port enq_rdy, output, 1, all selected queues can accept; control stalls on !enq_rdy.
REQ-008 SHALL have ports cmdq_val, output, 1; cmdq_rdy, input, 1; cmdq_bits, output, 20; vector-unit command dequeue.
REQ-009 SHALL have ports ximm1q_val, output, 1; ximm1q_rdy, input, 1; ximm1q_bits, output, 64; immediate-1 dequeue.
REQ-010 SHALL have ports ximm2q_val, output, 1; ximm2q_rdy, input, 1; ximm2q_bits, output, 32; immediate-2 dequeue.
REQ-011 SHALL have port cmdq_count, output, log2(DEPTH)+1, current command-queue occupancy.

Function
REQ-012 SHALL drive enq_rdy = AND over selected queues of (not full), from registered state only; no same-cycle dependence on any deq rdy.
REQ-013 SHALL define fire = enq_val & enq_rdy; on fire, push every selected queue in the same cycle (all-or-nothing, never a partial push).
REQ-014 SHALL treat enq_val with no queue selected as enq_rdy=1 and no state change.
REQ-015 SHALL drive each X_val = (count_X != 0); pop queue X on the clock edge where X_val & X_rdy.
REQ-016 SHALL present the head entry on X_bits combinationally from storage; content is don't-care when X_val=0.
REQ-017 SHALL have enqueue-to-dequeue latency of exactly one cycle; no bypass path from enq to an empty queue's outputs.
REQ-018 SHALL, on simultaneous push and pop of the same non-full, non-empty queue, leave its count unchanged and advance both pointers.
REQ-019 SHALL, when a queue is full, deassert enq_rdy for instructions selecting it even if that queue pops in the same cycle; the freed slot is usable the next cycle.
REQ-020 SHALL wrap read/write pointers modulo DEPTH; counts range 0..DEPTH with no overflow or underflow.
REQ-021 SHALL keep the three queues' dequeue sides fully independent of each other.

Reset
REQ-022 SHALL, while reset=1 (asynchronously), clear all pointers and counts, giving all X_val=0, cmdq_count=0, enq_rdy=1.
REQ-023 SHALL discard queued entries when reset asserts mid-operation; storage arrays are not reset.

Structure
REQ-024 SHALL place the payload widths (20/64/32) and the DEPTH default in the shared riscvConst.vh.
REQ-025 SHALL instantiate one generic FIFO sub-module, riscv_queue (parameters WIDTH, DEPTH; enq val/rdy, deq val/rdy, count), three times; atomic-enqueue logic lives in the top.

Verification
REQ-026 SHALL cover: push cmd=20'h4_0001, imm1=64'hDEAD, imm2=32'hBEEF with all rdy=1 -> all three val=1 next cycle with those values, popped the following edge, counts return to 0.
REQ-027 SHALL cover: 8 cmd-only pushes with cmdq_rdy=0 -> cmdq_count=8, enq_rdy=0 when enq_cmd=1, enq_rdy=1 for an imm1-only request.
REQ-028 SHALL cover: full cmdq, enq_val=1 enq_cmd=1, cmdq_rdy=1 -> no push that cycle, count 7, push accepted next cycle, count back to 8.
REQ-029 SHALL cover: ximm1q full, request selecting cmd+imm1 -> cmdq unchanged (no partial push) until ximm1q pops.
REQ-030 SHALL cover: 20 push/pop pairs on one queue -> FIFO order preserved across pointer wrap; reset asserted with count=5 -> count=0, val=0 immediately, asynchronously, before the next clock edge.
